router_output_allocator: RTL and testbench

Per-output-port switch allocator for the 5-port wormhole router. It picks which input port may drive one router output, round-robin among the eligible requesters. It holds that choice for the whole packet, until the tail flit is sent. It also tracks the credits of the downstream flit buffer so no flit is sent without a free slot. The router instantiates one allocator per output port, between the input flit FIFOs and the output crossbar mux.

---
 rtl/router_output_allocator_pkg.sv | 15 +
 rtl/router_output_allocator_if.sv | 32 +++
 rtl/router_output_allocator_rr_arbiter.sv | 47 ++++
 rtl/router_output_allocator.sv | 119 +++++++++++
 tb/tb_router_output_allocator.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/router_output_allocator_pkg.sv
// Shared types and helpers for the per-output switch allocator.
// Holds the allocator state encoding and the owner-index width rule.
package router_alloc_pkg;

  typedef enum logic {
    ALLOC_IDLE   = 1'b0,
    ALLOC_LOCKED = 1'b1
  } alloc_state_t;

  // A single-input allocator still needs a one-bit owner field.
  function automatic int owner_width(input int num_inputs);
    return (num_inputs > 1) ? $clog2(num_inputs) : 1;
  endfunction

endpackage

// File: rtl/router_output_allocator_if.sv
// Request/grant/credit bundle between the input FIFOs, crossbar and one output allocator.
// The slave modport is the allocator side.
interface router_output_allocator_if
  import router_alloc_pkg::*;
#(
  parameter int NUM_INPUTS   = 5,
  parameter int CREDIT_WIDTH = 1,
  parameter int OWNER_WIDTH  = owner_width(NUM_INPUTS)
);

  logic [NUM_INPUTS-1:0]   req;
  logic [NUM_INPUTS-1:0]   is_tail;
  logic [NUM_INPUTS-1:0]   disable_turn;
  logic [NUM_INPUTS-1:0]   grant;
  logic                    send;
  logic                    credit_in;
  logic [CREDIT_WIDTH-1:0] credits;
  logic                    locked;
  logic [OWNER_WIDTH-1:0]  owner;
  logic                    err_credit_ovf;

  modport master (
    output req, is_tail, disable_turn, credit_in,
    input  grant, send, credits, locked, owner, err_credit_ovf
  );

  modport slave (
    input  req, is_tail, disable_turn, credit_in,
    output grant, send, credits, locked, owner, err_credit_ovf
  );

endinterface

// File: rtl/router_output_allocator_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above rr_ptr, wrapping.
// Produces both the one-hot grant and its encoded index.
module rr_arbiter
  import router_alloc_pkg::*;
#(
  parameter int NUM_INPUTS = 5,
  parameter int IDX_WIDTH  = owner_width(NUM_INPUTS)
) (
  input  logic [NUM_INPUTS-1:0] req,
  input  logic [IDX_WIDTH-1:0]  rr_ptr,
  output logic [NUM_INPUTS-1:0] grant,
  output logic [IDX_WIDTH-1:0]  grant_idx
);

  logic [2*NUM_INPUTS-1:0] req_dbl;
  logic [NUM_INPUTS-1:0]   req_rot;
  logic [IDX_WIDTH-1:0]    offset;
  logic [IDX_WIDTH:0]      idx_sum;
  logic                    any_req;

  // Rotating the doubled vector puts rr_ptr at bit 0, so a plain
  // lowest-bit search gives the round-robin distance.
  assign req_dbl = {req, req};
  assign req_rot = req_dbl[rr_ptr +: NUM_INPUTS];
  assign any_req = |req;

  always_comb begin
    offset = '0;
    for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        offset = IDX_WIDTH'(k);
      end
    end
  end

  assign idx_sum   = {1'b0, rr_ptr} + {1'b0, offset};
  assign grant_idx = (idx_sum >= (IDX_WIDTH+1)'(NUM_INPUTS))
                   ? IDX_WIDTH'(idx_sum - (IDX_WIDTH+1)'(NUM_INPUTS))
                   : idx_sum[IDX_WIDTH-1:0];

  generate
    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_grant
      assign grant[gi] = any_req && (grant_idx == IDX_WIDTH'(gi));
    end
  endgenerate

endmodule

// File: rtl/router_output_allocator.sv
// Per-output wormhole switch allocator: round-robin packet-head arbitration, packet lock
// until tail, and downstream credit tracking with sticky overflow detection.
module router_output_allocator
  import router_alloc_pkg::*;
#(
  parameter int NUM_INPUTS        = 5,
  parameter int FLIT_BUFFER_DEPTH = 1,
  parameter int CREDIT_WIDTH      = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
  input  logic                      clk_noc,
  input  logic                      rst_n,
  router_output_allocator_if.slave  alloc_if
);

  localparam int OWNER_WIDTH = owner_width(NUM_INPUTS);
  localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);

  alloc_state_t            state_reg, state_next;
  logic [OWNER_WIDTH-1:0]  owner_reg, owner_next;
  logic [OWNER_WIDTH-1:0]  rr_ptr_reg, rr_ptr_next;
  logic [CREDIT_WIDTH-1:0] credits_reg, credits_next;
  logic                    err_reg, err_next;

  logic [NUM_INPUTS-1:0]   eligible;
  logic [NUM_INPUTS-1:0]   arb_grant;
  logic [OWNER_WIDTH-1:0]  arb_idx;
  logic [NUM_INPUTS-1:0]   grant;
  logic                    send;
  logic                    can_send;
  logic [CREDIT_WIDTH:0]   credits_sum;

  function automatic logic [OWNER_WIDTH-1:0] wrap_inc(input logic [OWNER_WIDTH-1:0] idx);
    return (idx == OWNER_WIDTH'(NUM_INPUTS - 1)) ? '0 : idx + 1'b1;
  endfunction

  assign eligible = alloc_if.req & ~alloc_if.disable_turn;
  assign can_send = (credits_reg != '0);

  rr_arbiter #(
    .NUM_INPUTS (NUM_INPUTS),
    .IDX_WIDTH  (OWNER_WIDTH)
  ) u_rr_arbiter (
    .req       (eligible),
    .rr_ptr    (rr_ptr_reg),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  always_comb begin
    state_next  = state_reg;
    owner_next  = owner_reg;
    rr_ptr_next = rr_ptr_reg;
    grant       = '0;
    // Grants are gated by rst_n so nothing pops while reset is held.
    if (rst_n && can_send) begin
      case (state_reg)
        ALLOC_IDLE: begin
          if (|arb_grant) begin
            grant = arb_grant;
            if (alloc_if.is_tail[arb_idx]) begin
              rr_ptr_next = wrap_inc(arb_idx);
            end else begin
              state_next = ALLOC_LOCKED;
              owner_next = arb_idx;
            end
          end
        end
        ALLOC_LOCKED: begin
          // Turn restrictions only gate packet heads; body flits just follow the lock.
          if (alloc_if.req[owner_reg]) begin
            grant[owner_reg] = 1'b1;
            if (alloc_if.is_tail[owner_reg]) begin
              state_next  = ALLOC_IDLE;
              rr_ptr_next = wrap_inc(owner_reg);
            end
          end
        end
        default: state_next = ALLOC_IDLE;
      endcase
    end
  end

  assign send = |grant;

  always_comb begin
    credits_sum = {1'b0, credits_reg}
                + (CREDIT_WIDTH+1)'(alloc_if.credit_in)
                - (CREDIT_WIDTH+1)'(send);
    credits_next = credits_sum[CREDIT_WIDTH-1:0];
    if (credits_sum > {1'b0, CREDIT_MAX}) begin
      credits_next = CREDIT_MAX;
    end
    err_next = err_reg | (alloc_if.credit_in && (credits_reg == CREDIT_MAX));
  end

  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ALLOC_IDLE;
      owner_reg   <= '0;
      rr_ptr_reg  <= '0;
      credits_reg <= CREDIT_MAX;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      owner_reg   <= owner_next;
      rr_ptr_reg  <= rr_ptr_next;
      credits_reg <= credits_next;
      err_reg     <= err_next;
    end
  end

  assign alloc_if.grant          = grant;
  assign alloc_if.send           = send;
  assign alloc_if.credits        = credits_reg;
  assign alloc_if.locked         = (state_reg == ALLOC_LOCKED);
  assign alloc_if.owner          = owner_reg;
  assign alloc_if.err_credit_ovf = err_reg;

endmodule

// File: tb/tb_router_output_allocator.sv
// Scoreboard bench for router_output_allocator (5 inputs, 4-deep downstream buffer):
// directed scenarios followed by random packet traffic against a packet-level model.
module tb_router_output_allocator;

  localparam int NI    = 5;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int OW    = $clog2(NI);

  typedef struct {
    int          cyc;
    logic [NI-1:0] grant;
    logic        send;
    int          credits;
    logic        locked;
    int          owner;
    logic        err;
  } exp_t;

  logic clk_noc = 1'b0;
  logic rst_n   = 1'b0;

  router_output_allocator_if #(.NUM_INPUTS(NI), .CREDIT_WIDTH(CW)) alloc_if ();

  router_output_allocator #(
    .NUM_INPUTS        (NI),
    .FLIT_BUFFER_DEPTH (DEPTH),
    .CREDIT_WIDTH      (CW)
  ) dut (
    .clk_noc  (clk_noc),
    .rst_n    (rst_n),
    .alloc_if (alloc_if)
  );

  always #5 clk_noc = ~clk_noc;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   last_win = -1;
  bit   stim_done = 1'b0;

  // Packet-level reference state: who holds the output, the fairness pointer,
  // and the downstream free-slot count.
  bit m_locked;
  int m_own;
  int m_rr;
  int m_cred;
  bit m_err;

  // cin_mode: 0 = no credit, 1 = credit pulse, 2 = downstream echoes this cycle's send
  task automatic step(input bit rst, input logic [NI-1:0] rq, input logic [NI-1:0] tl,
                      input logic [NI-1:0] dis, input int cin_mode);
    exp_t e;
    int   win;
    bit   cin;
    if (!rst) begin
      m_locked = 1'b0; m_own = 0; m_rr = 0; m_cred = DEPTH; m_err = 1'b0;
    end
    win = -1;
    if (rst && m_cred > 0) begin
      if (m_locked) begin
        if (rq[m_own]) win = m_own;
      end else begin
        for (int k = 0; k < NI; k++) begin
          int i;
          i = (m_rr + k) % NI;
          if (rq[i] && !dis[i]) begin
            win = i;
            break;
          end
        end
      end
    end
    cin = (cin_mode == 1) || (cin_mode == 2 && win >= 0);
    rst_n                 = rst;
    alloc_if.req          = rq;
    alloc_if.is_tail      = tl;
    alloc_if.disable_turn = dis;
    alloc_if.credit_in    = cin;
    e.cyc     = cyc;
    e.grant   = (win >= 0) ? NI'(1 << win) : '0;
    e.send    = (win >= 0);
    e.credits = m_cred;
    e.locked  = m_locked;
    e.owner   = m_own;
    e.err     = m_err;
    exp_q.push_back(e);
    last_win = win;
    @(posedge clk_noc);
    #1;
    cyc++;
    if (rst) begin
      if (cin && m_cred == DEPTH) m_err = 1'b1;
      m_cred = m_cred - ((win >= 0) ? 1 : 0) + (cin ? 1 : 0);
      if (m_cred > DEPTH) m_cred = DEPTH;
      if (win >= 0) begin
        if (tl[win]) begin
          m_locked = 1'b0;
          m_rr = (win + 1) % NI;
        end else begin
          m_locked = 1'b1;
          m_own = win;
        end
      end
    end
  endtask

  task automatic check(input string name, input int c, input int act, input int req_val);
    n_checks++;
    if (act != req_val) begin
      n_fail++;
      $display("FAIL %s cyc %0d got %0d expected %0d", name, c, act, req_val);
    end
  endtask

  // Monitor: compares the DUT outputs against the queued expectation each cycle.
  initial begin : monitor
    exp_t e;
    bit   stop;
    stop = 1'b0;
    while (!stop) begin
      @(negedge clk_noc);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        $display("cyc %0d rst_n %0b req %b grant %b send %0b credits %0d locked %0b",
                 e.cyc, rst_n, alloc_if.req, alloc_if.grant, alloc_if.send,
                 alloc_if.credits, alloc_if.locked);
        check("grant",   e.cyc, int'(alloc_if.grant),          int'(e.grant));
        check("send",    e.cyc, int'(alloc_if.send),           int'(e.send));
        check("credits", e.cyc, int'(alloc_if.credits),        e.credits);
        check("locked",  e.cyc, int'(alloc_if.locked),         int'(e.locked));
        check("err_ovf", e.cyc, int'(alloc_if.err_credit_ovf), int'(e.err));
        if (e.locked) check("owner", e.cyc, int'(alloc_if.owner), e.owner);
      end
      if (stim_done && exp_q.size() == 0) stop = 1'b1;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog cyc %0d got timeout expected finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int sent;
    int rem[NI];
    logic [NI-1:0] rq, tl, dis;
    alloc_if.req = '0; alloc_if.is_tail = '0; alloc_if.disable_turn = '0; alloc_if.credit_in = 1'b0;
    @(posedge clk_noc);
    #1;

    // Reset held for three cycles, then released.
    for (int c = 0; c < 3; c++) step(1'b0, 5'b10110, 5'b11111, 5'b00000, 0);
    step(1'b1, 5'b00000, 5'b00000, 5'b00000, 0);

    // Round-robin among single-flit packets.
    step(1'b1, 5'b10110, 5'b11111, 5'b00000, 0);
    for (int c = 0; c < 8; c++) step(1'b1, 5'b10110, 5'b11111, 5'b00000, 2);

    // Wormhole lock: 4-flit packet on input 3 with a 2-cycle gap; input 0 keeps asking.
    sent = 0;
    for (int c = 0; c < 10; c++) begin
      rq = 5'b00001;
      if (sent < 4 && !(c == 2 || c == 3)) rq[3] = 1'b1;
      tl = 5'b00001;
      tl[3] = (sent == 3);
      step(1'b1, rq, tl, 5'b00000, 2);
      if (last_win == 3) sent++;
    end

    // Credit stall: 6-flit packet on input 2 with sparse credit returns.
    sent = 0;
    for (int c = 0; c < 30 && sent < 6; c++) begin
      rq = '0; tl = '0;
      rq[2] = 1'b1;
      tl[2] = (sent == 5);
      step(1'b1, rq, tl, 5'b00000, (c >= 6 && c % 3 == 0) ? 1 : 0);
      if (last_win == 2) sent++;
    end

    // Turn mask blocks the only requester while credits refill.
    for (int c = 0; c < DEPTH; c++) step(1'b1, 5'b00010, 5'b00010, 5'b00010, 1);
    // Credit overflow is sticky.
    step(1'b1, 5'b00000, 5'b00000, 5'b00000, 1);
    for (int c = 0; c < 3; c++) step(1'b1, 5'b00000, 5'b00000, 5'b00000, 0);

    // Reset in the middle of a packet, then a fresh requester.
    step(1'b1, 5'b10000, 5'b00000, 5'b00000, 0);
    step(1'b1, 5'b10000, 5'b00000, 5'b00000, 0);
    step(1'b0, 5'b10000, 5'b00000, 5'b00000, 0);
    step(1'b0, 5'b10000, 5'b00000, 5'b00000, 0);
    step(1'b1, 5'b10010, 5'b00010, 5'b00000, 0);
    step(1'b1, 5'b10010, 5'b00000, 5'b00000, 0);

    // Random packet traffic.
    for (int i = 0; i < NI; i++) rem[i] = $urandom_range(1, 4);
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NI; i++) begin
        rq[i]  = ($urandom_range(0, 9) < 6);
        tl[i]  = (rem[i] == 1);
        dis[i] = ($urandom_range(0, 9) < 2);
      end
      step(1'b1, rq, tl, dis, (m_cred < DEPTH && $urandom_range(0, 1) == 1) ? 1 : 0);
      if (last_win >= 0) begin
        rem[last_win]--;
        if (rem[last_win] == 0) rem[last_win] = $urandom_range(1, 4);
      end
    end

    stim_done = 1'b1;
  end

endmodule
